// File: rtl/dmux8_way_pkg.sv
// Shared select-code constants and select types for the 8-way demultiplexer.
package dmux8_way_pkg;
  typedef logic [2:0] sel_t;
  typedef logic [1:0] sub_sel_t;

  localparam int NUM_OUT = 8;

  localparam sel_t SEL_A = 3'd0;
  localparam sel_t SEL_B = 3'd1;
  localparam sel_t SEL_C = 3'd2;
  localparam sel_t SEL_D = 3'd3;
  localparam sel_t SEL_E = 3'd4;
  localparam sel_t SEL_F = 3'd5;
  localparam sel_t SEL_G = 3'd6;
  localparam sel_t SEL_H = 3'd7;
endpackage

// File: rtl/dmux8_way_dmux4.sv
// 4-way demultiplexer: routes in to one of a..d, others held at zero.
module dmux4_way
  import dmux8_way_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in,
  input  sub_sel_t         sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);
  always_comb begin
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    case (sel)
      2'd0: a = in;
      2'd1: b = in;
      2'd2: c = in;
      2'd3: d = in;
    endcase
  end
endmodule

// File: rtl/dmux8_way.sv
// 8-way demultiplexer built from a sel[2] group split feeding two 4-way
// demuxes, with an optional output register stage.
module dmux8_way
  import dmux8_way_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  sel_t             sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h
);
  logic [WIDTH-1:0] in_lo, in_hi;
  logic [NUM_OUT-1:0][WIDTH-1:0] route, out_q;

  // Unselected group sees zero data, so its outputs are zero without X leakage.
  assign in_lo = sel[2] ? '0 : in;
  assign in_hi = sel[2] ? in : '0;

  dmux4_way #(.WIDTH(WIDTH)) u_lo (
    .in (in_lo),
    .sel(sel[1:0]),
    .a  (route[SEL_A]),
    .b  (route[SEL_B]),
    .c  (route[SEL_C]),
    .d  (route[SEL_D])
  );

  dmux4_way #(.WIDTH(WIDTH)) u_hi (
    .in (in_hi),
    .sel(sel[1:0]),
    .a  (route[SEL_E]),
    .b  (route[SEL_F]),
    .c  (route[SEL_G]),
    .d  (route[SEL_H])
  );

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= route;
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_q = route;
    end
  endgenerate

  assign a = out_q[SEL_A];
  assign b = out_q[SEL_B];
  assign c = out_q[SEL_C];
  assign d = out_q[SEL_D];
  assign e = out_q[SEL_E];
  assign f = out_q[SEL_F];
  assign g = out_q[SEL_G];
  assign h = out_q[SEL_H];
endmodule

// File: tb/tb_dmux8_way.sv
// Bench for dmux8_way: registered WIDTH=1 and WIDTH=16 instances plus a
// combinational instance, checked against a shift-based reference.
module tb_dmux8_way;
  import dmux8_way_pkg::*;

  typedef struct {
    sel_t       sel;
    logic       in;
    logic [7:0] exp;
  } vec_t;

  logic clk, rst_n;
  logic in1, inc;
  sel_t sel1, sel16, selc;
  logic [15:0] in16;
  logic a1, b1, c1, d1, e1, f1, g1, h1;
  logic ac, bc, cc, dc, ec, fc, gc, hc;
  logic [15:0] a16, b16, c16, d16, e16, f16, g16, h16;

  int total = 0;
  int bad   = 0;
  logic [7:0]   sb1[$];
  logic [127:0] sb16[$];
  vec_t tbl[$];

  dmux8_way #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1));

  dmux8_way #(.WIDTH(16), .REG_OUT(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in(in16), .sel(sel16),
    .a(a16), .b(b16), .c(c16), .d(d16), .e(e16), .f(f16), .g(g16), .h(h16));

  dmux8_way #(.WIDTH(1), .REG_OUT(1'b0)) dutc (
    .clk(clk), .rst_n(rst_n), .in(inc), .sel(selc),
    .a(ac), .b(bc), .c(cc), .d(dc), .e(ec), .f(fc), .g(gc), .h(hc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] model1(sel_t s, logic d);
    return 8'(d) << s;
  endfunction

  function automatic logic [127:0] model16(sel_t s, logic [15:0] d);
    return 128'(d) << (16 * int'(s));
  endfunction

  function automatic logic [7:0] o1();
    return {h1, g1, f1, e1, d1, c1, b1, a1};
  endfunction

  function automatic logic [7:0] oc();
    return {hc, gc, fc, ec, dc, cc, bc, ac};
  endfunction

  function automatic logic [127:0] o16();
    return {h16, g16, f16, e16, d16, c16, b16, a16};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  initial begin
    // one-hot sweep, zero-data sweep, then random mixes
    tbl.push_back('{3'd0, 1'b1, 8'h01});
    tbl.push_back('{3'd1, 1'b1, 8'h02});
    tbl.push_back('{3'd2, 1'b1, 8'h04});
    tbl.push_back('{3'd3, 1'b1, 8'h08});
    tbl.push_back('{3'd4, 1'b1, 8'h10});
    tbl.push_back('{3'd5, 1'b1, 8'h20});
    tbl.push_back('{3'd6, 1'b1, 8'h40});
    tbl.push_back('{3'd7, 1'b1, 8'h80});
    for (int i = 0; i < 8; i++) tbl.push_back('{sel_t'(i), 1'b0, 8'h00});
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v.sel = sel_t'($urandom_range(7));
      v.in  = 1'($urandom_range(1));
      v.exp = model1(v.sel, v.in);
      tbl.push_back(v);
    end

    rst_n = 1'b0; in1 = 1'b1; sel1 = 3'b011;
    in16 = 16'hFFFF; sel16 = 3'b011; inc = 1'b0; selc = 3'd0;

    // reset holds outputs at zero before and across edges
    #3;
    chk("rst_pre_1", 128'(o1()), 128'h0);
    chk("rst_pre_16", o16(), 128'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_edge_1", 128'(o1()), 128'h0);
      chk("rst_edge_16", o16(), 128'h0);
    end

    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_release_noglitch", 128'(o1()), 128'h0);
    @(posedge clk); #1;
    chk("rst_release_load", 128'(o1()), 128'h08);

    foreach (tbl[i]) begin
      @(negedge clk);
      in1 = tbl[i].in; sel1 = tbl[i].sel;
      sb1.push_back(tbl[i].exp);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_sel%0d_in%0d", i, tbl[i].sel, tbl[i].in), 128'(o1()), 128'(sb1.pop_front()));
    end

    // outputs hold between edges despite input glitches
    @(negedge clk); in1 = 1'b1; sel1 = SEL_H;
    @(posedge clk); #1;
    chk("hold_h", 128'(o1()), 128'h80);
    #1 sel1 = SEL_A;
    #1 in1 = 1'b0;
    #1 begin sel1 = SEL_C; in1 = 1'b1; end
    chk("hold_glitch", 128'(o1()), 128'h80);
    @(posedge clk); #1;
    chk("after_glitch_c", 128'(o1()), 128'h04);

    // wide data
    @(negedge clk); in16 = 16'hA5C3; sel16 = SEL_F;
    sb16.push_back(model16(SEL_F, 16'hA5C3));
    @(posedge clk); #1;
    chk("wide_f", o16(), sb16.pop_front());
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in16 = 16'($urandom); sel16 = sel_t'($urandom_range(7));
      sb16.push_back(model16(sel16, in16));
      @(posedge clk); #1;
      chk($sformatf("wide_rand%0d", i), o16(), sb16.pop_front());
    end

    // mid-operation reset clears asynchronously, next edge restores
    @(negedge clk); in1 = 1'b1; sel1 = SEL_G;
    @(posedge clk); #1;
    chk("mid_g_set", 128'(o1()), 128'h40);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_clear", 128'(o1()), 128'h0);
    #2 rst_n = 1'b1;
    #1 chk("mid_rst_release_noglitch", 128'(o1()), 128'h0);
    @(posedge clk); #1;
    chk("mid_rst_restore", 128'(o1()), 128'h40);

    // combinational instance: zero latency
    inc = 1'b1; selc = SEL_C;
    #1 chk("comb_c", 128'(oc()), 128'h04);
    selc = SEL_E;
    #1 chk("comb_e", 128'(oc()), 128'h10);
    for (int i = 0; i < 16; i++) begin
      selc = sel_t'(i % 8); inc = 1'(i / 8);
      #1 chk($sformatf("comb_sweep%0d", i), 128'(oc()), 128'(model1(selc, inc)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
